// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory bus arbiter.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DEF_NREQ    = 3;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 15;

    // Width able to hold 0..timeout-1; never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last_ptr, wrapping.
module rr_pick
    import mem_bus_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int PTR_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] last_ptr,
    output logic [NREQ-1:0]  pick,
    output logic [PTR_W-1:0] pick_idx,
    output logic             valid
);

    int idx;

    // Scan last_ptr+1 .. last_ptr+NREQ so the previous owner is checked last.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        valid    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_ptr) + k) % NREQ;
            if (!valid && req[idx]) begin
                valid     = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the shared memory/peripheral bus with access timeout.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [NREQ-1:0]        err,
    output logic [DATA_W-1:0]      rdata,
    output logic                   bus_cs,
    output logic                   bus_we,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [DATA_W-1:0]      bus_wdata,
    input  logic [DATA_W-1:0]      bus_rdata,
    input  logic                   bus_ready
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam int PTR_W = idx_width(NREQ);

    state_t             state;
    logic [PTR_W-1:0]   last_ptr;
    logic [PTR_W-1:0]   owner;
    logic [CNT_W-1:0]   cnt;

    logic [NREQ-1:0]    pick;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req      (req),
        .last_ptr (last_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .valid    (pick_valid)
    );

    // Grant / access / complete sequencer; all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_ptr  <= PTR_W'(NREQ - 1);
            owner     <= '0;
            cnt       <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            rdata     <= '0;
            bus_cs    <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    err  <= '0;
                    if (pick_valid) begin
                        gnt       <= pick;
                        owner     <= pick_idx;
                        bus_we    <= req_we[pick_idx];
                        bus_addr  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        bus_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        bus_cs    <= 1'b1;
                        cnt       <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Ready takes priority over a timeout landing in the same cycle.
                    if (bus_ready) begin
                        if (!bus_we) begin
                            rdata <= bus_rdata;
                        end
                        bus_cs <= 1'b0;
                        done   <= gnt;
                        state  <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rdata  <= '0;
                        bus_cs <= 1'b0;
                        done   <= gnt;
                        err    <= gnt;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done     <= '0;
                    err      <= '0;
                    gnt      <= '0;
                    last_ptr <= owner;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions, monitor checks completions.
module tb_mem_bus_arbiter;

    localparam int NREQ    = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   err;
    logic [DW-1:0]     rdata;
    logic              bus_cs;
    logic              bus_we;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic [DW-1:0]     bus_rdata;
    logic              bus_ready;

    mem_bus_arbiter #(
        .NREQ    (NREQ),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus_cs    (bus_cs),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  done;
        logic [2:0]  err;
        logic [31:0] rdata;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- bus responder ----------------
    int          rdy_delay  = 0;     // ready in cs cycle rdy_delay+1; -1 = never
    logic        stray      = 1'b0;
    logic        use_rd_val = 1'b0;
    logic [31:0] rd_val     = '0;
    int          k_cs       = 0;

    function automatic logic [31:0] addr_data(input logic [31:0] a);
        return a + 32'h1111_0000;
    endfunction

    always @(posedge clk) begin
        #1;
        if (bus_cs) k_cs++;
        else        k_cs = 0;
        bus_ready = (bus_cs && rdy_delay >= 0 && k_cs == rdy_delay + 1) || stray;
        bus_rdata = use_rd_val ? rd_val : addr_data(bus_addr);
    end

    // ---------------- monitor ----------------
    int          cur_len  = 0;
    int          last_len = 0;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cur_len = 0;
        end else begin
            if (bus_cs) begin
                if (cur_len == 0) begin
                    cap_we    = bus_we;
                    cap_addr  = bus_addr;
                    cap_wdata = bus_wdata;
                end
                cur_len++;
            end else if (cur_len > 0) begin
                last_len = cur_len;
                cur_len  = 0;
            end
            if (done != '0) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=%b expected none", done);
                end else begin
                    e = sb.pop_front();
                    chk("done",     64'(done),      64'(e.done));
                    chk("err",      64'(err),       64'(e.err));
                    chk("rdata",    64'(rdata),     64'(e.rdata));
                    chk("gnt_owner",64'(gnt),       64'(e.done));
                    chk("bus_we",   64'(cap_we),    64'(e.we));
                    chk("bus_addr", 64'(cap_addr),  64'(e.addr));
                    chk("bus_wdata",64'(cap_wdata), 64'(e.wdata));
                    chk("cs_len",   64'(last_len),  64'(e.len));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic push(input logic [2:0] d, input logic [2:0] e, input logic [31:0] rd,
                        input logic we, input logic [31:0] a, input logic [31:0] wd, input int len);
        exp_t x;
        x.done = d; x.err = e; x.rdata = rd; x.we = we; x.addr = a; x.wdata = wd; x.len = len;
        sb.push_back(x);
    endtask

    // Wait for a completion, then drop that requester's req in the following cycle.
    task automatic wait_done(input string name);
        logic [2:0] d;
        bit seen;
        seen = 0;
        d = '0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (done != '0) begin
                seen = 1;
                d = done;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
        end
        @(posedge clk);
        #1;
        req = req & ~d;
        chk({name, "_gnt_clear"}, 64'(gnt), 64'(0));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst       = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        bus_rdata = '0;
        bus_ready = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt",    64'(gnt),       64'(0));
        chk("rst_done",   64'(done),      64'(0));
        chk("rst_err",    64'(err),       64'(0));
        chk("rst_rdata",  64'(rdata),     64'(0));
        chk("rst_cs",     64'(bus_cs),    64'(0));
        chk("rst_bus",    {31'(0), bus_we, bus_addr}, 64'(0));
        chk("rst_wdata",  64'(bus_wdata), 64'(0));
        rst = 1'b0;
        cycles(2);

        // stray ready while idle must not produce anything
        stray = 1'b1;
        cycles(3);
        stray = 1'b0;
        chk("stray_cs", 64'(bus_cs), 64'(0));

        // single read, ready in third cs cycle
        use_rd_val = 1'b1;
        rd_val     = 32'hDEADBEEF;
        rdy_delay  = 2;
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        push(3'b001, 3'b000, 32'hDEADBEEF, 1'b0, 32'h0000_0100, 32'h0, 3);
        req = 3'b001;
        wait_done("single_read");
        use_rd_val = 1'b0;

        // write, rdata untouched
        rdy_delay = 0;
        set_req(1, 1'b1, 32'h4000_0004, 32'h0000_005A);
        push(3'b010, 3'b000, 32'hDEADBEEF, 1'b1, 32'h4000_0004, 32'h0000_005A, 1);
        req = 3'b010;
        wait_done("write");

        // timeout on requester 2
        rdy_delay = -1;
        set_req(2, 1'b0, 32'h8000_0010, 32'h0);
        push(3'b100, 3'b100, 32'h0, 1'b0, 32'h8000_0010, 32'h0, TIMEOUT);
        req = 3'b100;
        wait_done("timeout");

        // round robin: all three, last owner was 2
        rdy_delay = 0;
        set_req(0, 1'b0, 32'h0000_1000, 32'h0);
        set_req(1, 1'b0, 32'h0000_2000, 32'h0);
        set_req(2, 1'b0, 32'h0000_3000, 32'h0);
        push(3'b001, 3'b000, 32'h1111_1000, 1'b0, 32'h0000_1000, 32'h0, 1);
        push(3'b010, 3'b000, 32'h1111_2000, 1'b0, 32'h0000_2000, 32'h0, 1);
        push(3'b100, 3'b000, 32'h1111_3000, 1'b0, 32'h0000_3000, 32'h0, 1);
        req = 3'b111;
        wait_done("rr_a");
        wait_done("rr_b");
        wait_done("rr_c");

        // 011 with last owner 2: 0 then 1
        push(3'b001, 3'b000, 32'h1111_1000, 1'b0, 32'h0000_1000, 32'h0, 1);
        push(3'b010, 3'b000, 32'h1111_2000, 1'b0, 32'h0000_2000, 32'h0, 1);
        req = 3'b011;
        wait_done("rr_d");
        wait_done("rr_e");

        // ready in the final allowed cycle beats the timeout
        rdy_delay = TIMEOUT - 1;
        set_req(2, 1'b0, 32'h8000_0020, 32'h0);
        push(3'b100, 3'b000, 32'h9111_0020, 1'b0, 32'h8000_0020, 32'h0, TIMEOUT);
        req = 3'b100;
        wait_done("late_ready");

        // requester drops req mid-access; access still completes, no re-grant
        rdy_delay = 4;
        set_req(0, 1'b0, 32'h0000_0500, 32'h0);
        push(3'b001, 3'b000, 32'h1111_0500, 1'b0, 32'h0000_0500, 32'h0, 5);
        req = 3'b001;
        cycles(2);
        req = 3'b000;
        wait_done("drop_req");
        cycles(4);
        chk("drop_no_regrant_cs",  64'(bus_cs), 64'(0));
        chk("drop_no_regrant_gnt", 64'(gnt),    64'(0));

        // async reset during a hung read
        rdy_delay = -1;
        set_req(0, 1'b0, 32'h0000_0600, 32'h0);
        req = 3'b001;
        cycles(3);
        chk("pre_rst_cs", 64'(bus_cs), 64'(1));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_cs",   64'(bus_cs), 64'(0));
        chk("async_rst_gnt",  64'(gnt),    64'(0));
        chk("async_rst_done", 64'(done),   64'(0));
        req = 3'b000;
        cycles(2);
        @(negedge clk);
        rst = 1'b0;
        cycles(1);

        // after reset requester 1 beats requester 2
        rdy_delay = 0;
        set_req(1, 1'b0, 32'h0000_0700, 32'h0);
        set_req(2, 1'b0, 32'h0000_0800, 32'h0);
        push(3'b010, 3'b000, 32'h1111_0700, 1'b0, 32'h0000_0700, 32'h0, 1);
        push(3'b100, 3'b000, 32'h1111_0800, 1'b0, 32'h0000_0800, 32'h0, 1);
        req = 3'b110;
        wait_done("post_rst_a");
        wait_done("post_rst_b");

        cycles(3);
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
